// File: rtl/ysyx_041461_pkg.sv
// Shared defaults and index-width constant for the register scoreboard.
package ysyx_041461_pkg;
    localparam int NR_REGS_DEF = 32;
    localparam int CNT_W_DEF   = 2;
    localparam int NR_SRC_DEF  = 3;
    localparam int REG_IDX_W   = $clog2(NR_REGS_DEF);
endpackage

// File: rtl/ysyx_041461_sb_cnt.sv
// Saturating up/down in-flight counter; simultaneous inc and dec cancel out.
module ysyx_041461_sb_cnt
    import ysyx_041461_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/ysyx_041461_scoreboard.sv
// Per-register write-in-flight scoreboard. Optional CSR hazard tracking is
// enabled by defining YSYX_041461_SB_CSR_EN.
module ysyx_041461_scoreboard
    import ysyx_041461_pkg::*;
#(
    parameter int NR_REGS = NR_REGS_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NR_SRC  = NR_SRC_DEF,
    localparam int IDX_W  = $clog2(NR_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    iss_valid,
    input  logic                    iss_rd_wen,
    input  logic [IDX_W-1:0]        iss_rd,
    output logic                    iss_ready,
    input  logic [NR_SRC-1:0]       src_valid,
    input  logic [NR_SRC*IDX_W-1:0] src_idx,
    output logic [NR_SRC-1:0]       src_busy,
    output logic                    stall,
    input  logic                    wb_valid,
    input  logic [IDX_W-1:0]        wb_rd,
    input  logic                    flush,
`ifdef YSYX_041461_SB_CSR_EN
    input  logic                    iss_csr_wen,
    input  logic                    wb_csr_valid,
    input  logic                    csr_rd_valid,
    output logic                    csr_busy,
`endif
    output logic [NR_REGS-1:0]      busy_vec,
    output logic                    err_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt_arr [NR_REGS];
    logic [NR_REGS-1:0] zero_vec;
    logic               rd_sat, csr_sat, csr_uf;
    logic               iss_accept, wb_live;
    logic               err_q, err_d;

    assign rd_sat     = iss_rd_wen && (cnt_arr[iss_rd] == CNT_MAX);
    assign iss_ready  = !(rd_sat || csr_sat);
    assign iss_accept = iss_valid && iss_ready && !flush;
    // x0 is never tracked, so writebacks to it are ignored rather than underflowing.
    assign wb_live    = wb_valid && !flush && (wb_rd != '0);

    for (genvar i = 0; i < NR_REGS; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign cnt_arr[i]  = '0;
            assign zero_vec[i] = 1'b1;
        end else begin : g_cnt
            logic inc, dec;
            assign inc = iss_accept && iss_rd_wen && (iss_rd == IDX_W'(i));
            assign dec = wb_live && (wb_rd == IDX_W'(i));
            ysyx_041461_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc),
                .dec   (dec),
                .clr   (flush),
                .cnt   (cnt_arr[i]),
                .zero  (zero_vec[i])
            );
        end
    end

    assign busy_vec = ~zero_vec;

    for (genvar k = 0; k < NR_SRC; k++) begin : g_src
        assign src_busy[k] = src_valid[k] && busy_vec[src_idx[k*IDX_W +: IDX_W]];
    end

`ifdef YSYX_041461_SB_CSR_EN
    logic [CNT_W-1:0] csr_cnt;
    logic             csr_zero;

    ysyx_041461_sb_cnt #(.CNT_W(CNT_W)) u_csr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (iss_accept && iss_csr_wen),
        .dec   (wb_csr_valid && !flush),
        .clr   (flush),
        .cnt   (csr_cnt),
        .zero  (csr_zero)
    );

    assign csr_sat  = iss_csr_wen && (csr_cnt == CNT_MAX);
    assign csr_uf   = wb_csr_valid && !flush && csr_zero;
    assign csr_busy = csr_rd_valid && !csr_zero;
    assign stall    = (|src_busy) || csr_busy;
`else
    assign csr_sat  = 1'b0;
    assign csr_uf   = 1'b0;
    assign stall    = |src_busy;
`endif

    assign err_d = err_q || (wb_live && zero_vec[wb_rd]) || csr_uf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;
endmodule

// File: tb/tb_ysyx_041461_scoreboard.sv
// Directed self-checking bench for the register scoreboard (default parameters).
module tb_ysyx_041461_scoreboard;
    import ysyx_041461_pkg::*;

    localparam int NR_REGS = NR_REGS_DEF;
    localparam int NR_SRC  = NR_SRC_DEF;
    localparam int IDX_W   = REG_IDX_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    iss_valid, iss_rd_wen, iss_ready;
    logic [IDX_W-1:0]        iss_rd;
    logic [NR_SRC-1:0]       src_valid, src_busy;
    logic [NR_SRC*IDX_W-1:0] src_idx;
    logic                    stall, wb_valid, flush, err_underflow;
    logic [IDX_W-1:0]        wb_rd;
    logic [NR_REGS-1:0]      busy_vec;
`ifdef YSYX_041461_SB_CSR_EN
    logic                    iss_csr_wen, wb_csr_valid, csr_rd_valid, csr_busy;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ysyx_041461_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iss_valid     (iss_valid),
        .iss_rd_wen    (iss_rd_wen),
        .iss_rd        (iss_rd),
        .iss_ready     (iss_ready),
        .src_valid     (src_valid),
        .src_idx       (src_idx),
        .src_busy      (src_busy),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
`ifdef YSYX_041461_SB_CSR_EN
        .iss_csr_wen   (iss_csr_wen),
        .wb_csr_valid  (wb_csr_valid),
        .csr_rd_valid  (csr_rd_valid),
        .csr_busy      (csr_busy),
`endif
        .busy_vec      (busy_vec),
        .err_underflow (err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rd_wen = 1'b0; iss_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        src_valid = '0; src_idx = '0;
`ifdef YSYX_041461_SB_CSR_EN
        iss_csr_wen = 1'b0; wb_csr_valid = 1'b0; csr_rd_valid = 1'b0;
`endif
    endtask

    task automatic issue(input int rd);
        iss_valid = 1'b1; iss_rd_wen = 1'b1; iss_rd = IDX_W'(rd);
    endtask

    task automatic wb(input int rd);
        wb_valid = 1'b1; wb_rd = IDX_W'(rd);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) tick();
        iss_rd_wen = 1'b1; iss_rd = 5'd7; src_valid = 3'b111; src_idx = {3{5'd7}};
        settle();
        chk("rst_busy_vec", busy_vec, 32'h0);
        chk("rst_err", {31'b0, err_underflow}, 32'h0);
        chk("rst_iss_ready", {31'b0, iss_ready}, 32'h1);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        idle();
        rst_n = 1'b1;

        // Issue rd=5, query it, then retire it.
        issue(5); src_valid = 3'b001; src_idx = {10'd0, 5'd5};
        settle();
        chk("iss5_latency_busy", {29'b0, src_busy}, 32'h0);
        tick();
        iss_valid = 1'b0; iss_rd_wen = 1'b0;
        settle();
        chk("iss5_busy_vec", busy_vec, 32'h0000_0020);
        chk("iss5_src_busy", {29'b0, src_busy}, 32'h1);
        chk("iss5_stall", {31'b0, stall}, 32'h1);
        wb(5);
        settle();
        chk("wb5_same_cycle_busy", {29'b0, src_busy}, 32'h1);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("wb5_src_free", {29'b0, src_busy}, 32'h0);
        chk("wb5_stall_free", {31'b0, stall}, 32'h0);
        idle();

        // Saturate rd=7, attempt a fourth issue, then drain.
        issue(7);
        repeat (3) tick();
        settle();
        chk("sat7_ready", {31'b0, iss_ready}, 32'h0);
        chk("sat7_busy_vec", busy_vec, 32'h0000_0080);
        tick();
        iss_valid = 1'b0;
        settle();
        chk("sat7_ready_hold", {31'b0, iss_ready}, 32'h0);
        iss_rd_wen = 1'b0;
        settle();
        chk("sat7_ready_no_wen", {31'b0, iss_ready}, 32'h1);
        iss_rd_wen = 1'b1;
        wb(7);
        repeat (2) tick();
        wb_valid = 1'b0;
        settle();
        chk("sat7_two_wb_busy", busy_vec, 32'h0000_0080);
        chk("sat7_ready_after_wb", {31'b0, iss_ready}, 32'h1);
        iss_rd_wen = 1'b0;
        wb(7);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("sat7_drained", busy_vec, 32'h0);
        chk("sat7_no_err", {31'b0, err_underflow}, 32'h0);

        // Simultaneous issue and writeback to rd=9 with count 1.
        issue(9);
        tick();
        wb(9);
        tick();
        idle();
        settle();
        chk("same9_busy", busy_vec, 32'h0000_0200);
        wb(9);
        tick();
        idle();
        settle();
        chk("same9_drained", busy_vec, 32'h0);

        // Register 0 is never tracked.
        issue(0);
        tick();
        idle();
        src_valid = 3'b111; src_idx = '0;
        settle();
        chk("x0_busy_vec", busy_vec, 32'h0);
        chk("x0_src_busy", {29'b0, src_busy}, 32'h0);
        chk("x0_stall", {31'b0, stall}, 32'h0);
        idle();
        wb(0);
        tick();
        idle();
        settle();
        chk("x0_wb_no_err", {31'b0, err_underflow}, 32'h0);

        // Flush wipes x4..x7 and drops the concurrent issue to x3.
        for (int r = 4; r < 8; r++) begin
            issue(r);
            tick();
        end
        idle();
        settle();
        chk("pre_flush_busy", busy_vec, 32'h0000_00F0);
        issue(3); flush = 1'b1;
        tick();
        idle();
        settle();
        chk("flush_busy", busy_vec, 32'h0);
        chk("flush_no_err", {31'b0, err_underflow}, 32'h0);
        wb(4);
        tick();
        idle();
        settle();
        chk("uf_err_set", {31'b0, err_underflow}, 32'h1);
        flush = 1'b1;
        tick();
        idle();
        settle();
        chk("uf_err_sticky", {31'b0, err_underflow}, 32'h1);

        // Port packing: port0 -> x12 (masked), port1 -> x10, port2 -> x11.
        issue(10);
        tick();
        issue(12);
        tick();
        idle();
        src_valid = 3'b110; src_idx = {5'd11, 5'd10, 5'd12};
        settle();
        chk("multi_busy_vec", busy_vec, 32'h0000_1400);
        chk("multi_src_busy", {29'b0, src_busy}, 32'h2);

        // Mid-cycle asynchronous reset.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy_vec", busy_vec, 32'h0);
        chk("async_src_busy", {29'b0, src_busy}, 32'h0);
        chk("async_err", {31'b0, err_underflow}, 32'h0);
        idle();
        tick();
        rst_n = 1'b1;

`ifdef YSYX_041461_SB_CSR_EN
        iss_valid = 1'b1; iss_csr_wen = 1'b1;
        tick();
        idle();
        csr_rd_valid = 1'b1;
        settle();
        chk("csr_busy", {31'b0, csr_busy}, 32'h1);
        chk("csr_stall", {31'b0, stall}, 32'h1);
        wb_csr_valid = 1'b1;
        settle();
        chk("csr_wb_same_cycle", {31'b0, stall}, 32'h1);
        tick();
        wb_csr_valid = 1'b0;
        settle();
        chk("csr_free", {31'b0, stall}, 32'h0);
        iss_valid = 1'b1; iss_csr_wen = 1'b1;
        tick();
        iss_valid = 1'b0; iss_csr_wen = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("csr_async_busy", {31'b0, csr_busy}, 32'h0);
        chk("csr_async_stall", {31'b0, stall}, 32'h0);
        idle();
        tick();
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ysyx_041461_scoreboard.md
YSYX_041461_SCOREBOARD -- requirements
Module: ysyx_041461_scoreboard

Interface
REQ-001 Parameter NR_REGS, default 32: number of tracked integer registers; index width is log2(NR_REGS).
REQ-002 Parameter CNT_W, default 2: width of each per-register in-flight counter; the maximum count is 2^CNT_W-1.
REQ-003 Parameter NR_SRC, default 3: number of source-register query ports.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port iss_valid, input, 1: an instruction issues this cycle.
REQ-007 Port iss_rd_wen, input, 1: the issuing instruction writes rd.
REQ-008 Port iss_rd, input, log2(NR_REGS): destination index of the issuing instruction.
REQ-009 Port iss_ready, output, 1: issue is accepted this cycle.
REQ-010 Port src_valid, input, NR_SRC: per-port query enable.
REQ-011 Port src_idx, input, NR_SRC*log2(NR_REGS): packed source indices, port 0 in the LSBs.
REQ-012 Port src_busy, output, NR_SRC: the queried register has a pending write.
REQ-013 Port stall, output, 1: OR of src_busy.
REQ-014 Port wb_valid, input, 1: writeback retires a write.
REQ-015 Port wb_rd, input, log2(NR_REGS): index of the retiring write.
REQ-016 Port flush, input, 1: pipeline flush on trap or redirect.
REQ-017 Port busy_vec, output, NR_REGS: bit i is set when counter i is non-zero.
REQ-018 Port err_underflow, output, 1: sticky flag, set on a writeback to a register whose counter is zero.

Function
REQ-019 Each register i shall have a counter cnt[i] of CNT_W bits; index 0 shall never be tracked, so its counter stays 0 and it is never busy.
REQ-020 iss_ready shall be 0 when iss_rd_wen=1 and cnt[iss_rd]=2^CNT_W-1 (saturated); otherwise iss_ready shall be 1.
REQ-021 Issue acceptance: iss_valid && iss_ready && iss_rd_wen && iss_rd!=0 && !flush shall increment cnt[iss_rd] on the next edge.
REQ-022 Writeback: wb_valid && wb_rd!=0 && !flush && cnt[wb_rd]!=0 shall decrement cnt[wb_rd] on the next edge.
REQ-023 An accepted issue and a writeback to the same register in the same cycle shall leave the counter unchanged.
REQ-024 A writeback to a register with a zero count shall leave the counter unchanged and set err_underflow.
REQ-025 src_busy[k] shall equal src_valid[k] && cnt[src_idx[k]]!=0, combinationally from registered state.
REQ-026 A same-cycle writeback shall not clear src_busy; the register reads as free in the cycle after the decrement edge.
REQ-027 Flush shall zero all counters on the next edge; issue and writeback in the flush cycle shall be ignored.
REQ-028 Flush shall not clear err_underflow.
REQ-029 Latency: an accepted issue shall make busy_vec and src_busy assert one cycle later.

Reset
REQ-030 While rst_n=0, all counters shall be 0, err_underflow 0 and busy_vec 0; iss_ready shall read 1 and stall shall read 0.
REQ-031 Assertion of rst_n mid-operation shall discard all pending state immediately, without waiting for a clock edge.

Configuration
REQ-032 Macro YSYX_041461_SB_CSR_EN shall control CSR hazard tracking.
REQ-033 When YSYX_041461_SB_CSR_EN is defined, the following ports shall be added: iss_csr_wen (input, 1), wb_csr_valid (input, 1), csr_rd_valid (input, 1) and csr_busy (output, 1).
REQ-034 When YSYX_041461_SB_CSR_EN is defined, one global CNT_W-bit CSR counter shall apply the same increment, decrement, saturation, flush and underflow rules as the register counters.
REQ-035 When YSYX_041461_SB_CSR_EN is defined, csr_busy shall equal csr_rd_valid && csr_cnt!=0, and csr_busy shall also be ORed into stall.
REQ-036 When YSYX_041461_SB_CSR_EN is not defined, those ports and that counter shall not exist, and stall shall depend on src_busy only.

Structure
REQ-037 The shared package ysyx_041461_pkg shall hold the default NR_REGS, CNT_W and NR_SRC values and the register-index width constant.
REQ-038 The block shall have one sub-module, ysyx_041461_sb_cnt: a single saturating up/down counter with inc, dec, clr and rst_n inputs and cnt and zero outputs, instantiated per register (and for the CSR counter when enabled).

Verification
REQ-039 Issue rd=5, then src_idx[0]=5 with src_valid[0]=1 -> src_busy[0]=1 and stall=1; after wb_rd=5, the next cycle shows src_busy[0]=0.
REQ-040 Three issues to rd=7 with CNT_W=2 -> cnt=3, then a fourth issue -> iss_ready=0 and cnt stays 3; three writebacks -> busy_vec[7]=0.
REQ-041 Issue and writeback to rd=9 in the same cycle with cnt=1 -> cnt stays 1 and busy_vec[9]=1.
REQ-042 Issue or query rd=0 -> busy_vec[0]=0 and src_busy=0 at all times.
REQ-043 With busy_vec=0x00F0, pulse flush together with an issue to rd=3 -> busy_vec=0 next cycle; a writeback to rd=4 afterwards -> err_underflow=1, which stays set after a further flush.
REQ-044 With YSYX_041461_SB_CSR_EN defined, issue a CSR write, then csr_rd_valid=1 -> stall=1 until one cycle after wb_csr_valid; assert rst_n=0 mid-sequence -> all outputs return to reset values asynchronously.
